// File: rtl/rdma_pkg.sv
// Shared types for the two-way RDMA transmit stream arbiter.
package rdma_pkg;
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2
    } arb_state_t;

    localparam logic SRC0 = 1'b0;
    localparam logic SRC1 = 1'b1;
endpackage

// File: rtl/rdma_stream_arbiter.sv
// Round-robin burst arbiter: shares one address+data stream pair between two
// RDMA transmit sources, holding the grant from address beat through TLAST.
module rdma_stream_arbiter
    import rdma_pkg::*;
#(
    parameter int AXI_DATA_WIDTH = 512,
    parameter int AXI_ADDR_WIDTH = 64
) (
    input  logic                      clk,
    input  logic                      resetn,
    input  logic [AXI_ADDR_WIDTH-1:0] S0_ADDR_TDATA,
    input  logic                      S0_ADDR_TVALID,
    output logic                      S0_ADDR_TREADY,
    input  logic [AXI_DATA_WIDTH-1:0] S0_DATA_TDATA,
    input  logic                      S0_DATA_TVALID,
    input  logic                      S0_DATA_TLAST,
    output logic                      S0_DATA_TREADY,
    input  logic [AXI_ADDR_WIDTH-1:0] S1_ADDR_TDATA,
    input  logic                      S1_ADDR_TVALID,
    output logic                      S1_ADDR_TREADY,
    input  logic [AXI_DATA_WIDTH-1:0] S1_DATA_TDATA,
    input  logic                      S1_DATA_TVALID,
    input  logic                      S1_DATA_TLAST,
    output logic                      S1_DATA_TREADY,
    output logic [AXI_ADDR_WIDTH-1:0] M_ADDR_TDATA,
    output logic                      M_ADDR_TVALID,
    input  logic                      M_ADDR_TREADY,
    output logic [AXI_DATA_WIDTH-1:0] M_DATA_TDATA,
    output logic                      M_DATA_TVALID,
    output logic                      M_DATA_TLAST,
    input  logic                      M_DATA_TREADY,
    output logic                      GRANT,
    output logic                      BUSY,
    output logic [31:0]               BURSTS0,
    output logic [31:0]               BURSTS1
);

    arb_state_t  r_state;
    logic        r_grant;
    logic        r_last_grant;
    logic [31:0] r_bursts0;
    logic [31:0] r_bursts1;

    logic w_in_addr;
    logic w_in_data;
    logic w_sel;
    logic w_addr_hs;
    logic w_last_hs;

    // Ties go to the source that did not win last time.
    function automatic logic rr_pick(input logic req0, input logic req1, input logic last);
        if (req0 && req1)
            return ~last;
        else if (req1)
            return SRC1;
        else
            return SRC0;
    endfunction

    assign w_in_addr = (r_state == ADDR);
    assign w_in_data = (r_state == DATA);
    // Source 0 is presented on the data lanes while idle.
    assign w_sel     = (r_state != IDLE) && (r_grant == SRC1);

    assign M_ADDR_TDATA  = w_sel ? S1_ADDR_TDATA : S0_ADDR_TDATA;
    assign M_ADDR_TVALID = w_in_addr && (w_sel ? S1_ADDR_TVALID : S0_ADDR_TVALID);
    assign M_DATA_TDATA  = w_sel ? S1_DATA_TDATA : S0_DATA_TDATA;
    assign M_DATA_TLAST  = w_sel ? S1_DATA_TLAST : S0_DATA_TLAST;
    assign M_DATA_TVALID = w_in_data && (w_sel ? S1_DATA_TVALID : S0_DATA_TVALID);

    assign S0_ADDR_TREADY = w_in_addr && (r_grant == SRC0) && M_ADDR_TREADY;
    assign S1_ADDR_TREADY = w_in_addr && (r_grant == SRC1) && M_ADDR_TREADY;
    assign S0_DATA_TREADY = w_in_data && (r_grant == SRC0) && M_DATA_TREADY;
    assign S1_DATA_TREADY = w_in_data && (r_grant == SRC1) && M_DATA_TREADY;

    assign w_addr_hs = M_ADDR_TVALID && M_ADDR_TREADY;
    assign w_last_hs = M_DATA_TVALID && M_DATA_TREADY && M_DATA_TLAST;

    assign GRANT   = r_grant;
    assign BUSY    = (r_state != IDLE);
    assign BURSTS0 = r_bursts0;
    assign BURSTS1 = r_bursts1;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state      <= IDLE;
            r_grant      <= SRC0;
            r_last_grant <= SRC1;
            r_bursts0    <= '0;
            r_bursts1    <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (S0_ADDR_TVALID || S1_ADDR_TVALID) begin
                        r_grant <= rr_pick(S0_ADDR_TVALID, S1_ADDR_TVALID, r_last_grant);
                        r_state <= ADDR;
                    end
                end
                ADDR: begin
                    if (w_addr_hs)
                        r_state <= DATA;
                end
                DATA: begin
                    // Mid-burst valid gaps simply stall here; only TLAST releases.
                    if (w_last_hs) begin
                        r_last_grant <= r_grant;
                        if (r_grant == SRC0)
                            r_bursts0 <= r_bursts0 + 32'd1;
                        else
                            r_bursts1 <= r_bursts1 + 32'd1;
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule
